// File: rtl/reg_file_param.sv
// Parametrised integer register file: byte-masked write port, two bypassed
// read ports, per-entry pending bits and a multi-cycle sweep-clear engine.
module reg_file_param #(
   parameter int DATA_W   = 64,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                write,
   input  logic [ADDR_W-1:0]   wrAddr,
   input  logic [DATA_W-1:0]   wrData,
   input  logic [DATA_W/8-1:0] wrMask,
   input  logic [ADDR_W-1:0]   rdAddrA,
   input  logic [ADDR_W-1:0]   rdAddrB,
   output logic [DATA_W-1:0]   rdDataA,
   output logic [DATA_W-1:0]   rdDataB,
   output logic                rdBusyA,
   output logic                rdBusyB,
   input  logic                pendSet,
   input  logic [ADDR_W-1:0]   pendAddr,
   input  logic                clrStart,
   output logic                clrBusy
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DEPTH-1:0]    r_pend;
   logic [ADDR_W-1:0]   r_ptr;

   logic                w_idle;
   logic                w_wr_ok;
   logic                w_ps_ok;
   logic                w_byp_a;
   logic                w_byp_b;
   logic [DATA_W-1:0]   w_bmask;
   logic [DATA_W-1:0]   w_merge;

   // Entry is addressable, and not the hardwired zero register
   function automatic logic f_ok(input logic [ADDR_W-1:0] a);
      f_ok = ({1'b0, a} < LP_DEPTH) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
      f_idx = a[IDX_W-1:0];
   endfunction

   assign w_idle  = (r_state == S_IDLE);
   assign w_wr_ok = write && w_idle && f_ok(wrAddr);
   assign w_ps_ok = pendSet && w_idle && f_ok(pendAddr);
   assign w_byp_a = (BYPASS != 0) && w_wr_ok && (wrAddr == rdAddrA);
   assign w_byp_b = (BYPASS != 0) && w_wr_ok && (wrAddr == rdAddrB);
   assign clrBusy = (r_state == S_CLEAR);

   always_comb begin
      w_bmask = '0;
      for (int i = 0; i < NB; i++)
         w_bmask[8*i +: 8] = {8{wrMask[i]}};
   end

   assign w_merge = (r_mem[f_idx(wrAddr)] & ~w_bmask) | (wrData & w_bmask);

   always_comb begin
      rdDataA = '0;
      rdBusyA = 1'b0;
      if (f_ok(rdAddrA)) begin
         if (w_byp_a) begin
            rdDataA = w_merge;
         end else begin
            rdDataA = r_mem[f_idx(rdAddrA)];
            rdBusyA = r_pend[f_idx(rdAddrA)];
         end
      end
   end

   always_comb begin
      rdDataB = '0;
      rdBusyB = 1'b0;
      if (f_ok(rdAddrB)) begin
         if (w_byp_b) begin
            rdDataB = w_merge;
         end else begin
            rdDataB = r_mem[f_idx(rdAddrB)];
            rdBusyB = r_pend[f_idx(rdAddrB)];
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_IDLE:  if (clrStart) w_state_nx = S_CLEAR;
         S_CLEAR: if (r_ptr == LP_LAST) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_pend  <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         r_state <= w_state_nx;
         if (r_state == S_CLEAR) begin
            r_mem[f_idx(r_ptr)]  <= '0;
            r_pend[f_idx(r_ptr)] <= 1'b0;
            r_ptr                <= r_ptr + ADDR_W'(1);
         end else begin
            if (clrStart)
               r_ptr <= '0;
            if (w_wr_ok) begin
               r_mem[f_idx(wrAddr)]  <= w_merge;
               r_pend[f_idx(wrAddr)] <= 1'b0;
            end
            // Later assignment: pendSet wins over a same-cycle write
            if (w_ps_ok)
               r_pend[f_idx(pendAddr)] <= 1'b1;
         end
      end
   end

endmodule
